// File: rtl/fabric_initiator.sv
// fabric_initiator - host command FIFO and single-outstanding request master for fabric_simple.
// Issues one-cycle read/write strobes, waits for the fabric handshake, returns one response per command.
module fabric_initiator #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             read_req,
  output logic             write_req,
  output logic [WIDTH-1:0] write_data,
  input  logic [WIDTH-1:0] read_data,
  input  logic             req_valid,
  input  logic             resp_valid,
  output logic             busy,
  output logic [7:0]       err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t state, state_n;

  logic [1:0]       op_mem   [DEPTH];
  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [1:0]       op_q;
  logic [TW-1:0]    tcount;

  logic             push, pop, issue, resp_load, tcount_inc, resp_err_n;
  logic [WIDTH-1:0] resp_data_n;
  logic [1:0]       head_op;
  logic [WIDTH-1:0] head_data;

  assign cmd_ready = (count != CW'(DEPTH));
  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE) || (count != '0);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == S_IDLE) && (count != '0);
  assign head_op   = op_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  // Storage needs no reset: only the pointers and count define valid contents.
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr]   <= cmd_op;
      data_mem[wr_ptr] <= cmd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n     = state;
    issue       = 1'b0;
    resp_load   = 1'b0;
    resp_err_n  = 1'b0;
    resp_data_n = '0;
    tcount_inc  = 1'b0;
    case (state)
      S_IDLE: begin
        if (pop) begin
          if (head_op == 2'b00) begin
            state_n    = S_RESP;
            resp_load  = 1'b1;
            resp_err_n = 1'b1;
          end else begin
            state_n = S_WAIT;
            issue   = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (resp_valid) begin
          state_n   = S_RESP;
          resp_load = 1'b1;
          if (req_valid) resp_data_n = op_q[0] ? read_data : '0;
          else           resp_err_n  = 1'b1;
        end else if (tcount == TW'(TIMEOUT)) begin
          state_n    = S_RESP;
          resp_load  = 1'b1;
          resp_err_n = 1'b1;
        end else begin
          tcount_inc = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_req   <= 1'b0;
      write_req  <= 1'b0;
      write_data <= '0;
      op_q       <= 2'b00;
      tcount     <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      err_count  <= 8'd0;
    end else begin
      // Strobes are only ever set on the issue edge, so each is one cycle wide.
      read_req  <= issue && head_op[0];
      write_req <= issue && head_op[1];
      if (issue) begin
        write_data <= head_data;
        op_q       <= head_op;
        tcount     <= '0;
      end else if (tcount_inc) begin
        tcount <= tcount + 1'b1;
      end
      if (resp_load) begin
        rsp_data <= resp_data_n;
        rsp_err  <= resp_err_n;
      end
      if ((state == S_RESP) && rsp_ready && rsp_err && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_fabric_initiator.sv
// tb_fabric_initiator - table-driven and scoreboarded bench for fabric_initiator with a fabric_simple model.
module tb_fabric_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_data;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data;
  logic        read_req, write_req;
  logic [31:0] write_data, read_data;
  logic        req_valid, resp_valid, busy;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;
  int mode   = 0;  // 0 normal fabric, 1 silent stub, 2 resp_valid without req_valid
  int ecnt   = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    int          mode;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;
  vec_t tbl[8];

  fabric_initiator #(.WIDTH(32), .DEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .read_req(read_req), .write_req(write_req), .write_data(write_data),
    .read_data(read_data), .req_valid(req_valid), .resp_valid(resp_valid),
    .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // fabric_simple model: registers the strobe and answers one cycle later
  logic [31:0] fmem;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      req_valid  <= 1'b0;
      read_data  <= 32'h0;
    end else begin
      case (mode)
        1: begin
          resp_valid <= 1'b0;
          req_valid  <= 1'b0;
        end
        2: begin
          resp_valid <= read_req | write_req;
          req_valid  <= 1'b0;
        end
        default: begin
          resp_valid <= read_req | write_req;
          req_valid  <= read_req | write_req;
          if (write_req) fmem <= write_data;
          if (read_req | write_req) read_data <= write_req ? write_data : fmem;
        end
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got data %h err %0d expected none", rsp_data, rsp_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [1:0] op, input logic [31:0] data,
                          input logic [31:0] exp_data, input logic exp_err,
                          output logic accepted);
    exp_t e;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    accepted  = cmd_ready;
    if (accepted) begin
      e.data = exp_data;
      e.err  = exp_err;
      sb.push_back(e);
      if (exp_err) ecnt++;
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input int limit, input string name);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    chk({name, "_drained"}, sb.size(), 0);
  endtask

  task automatic check_reset(input string name);
    chk({name, "_cmd_ready"}, {31'b0, cmd_ready}, 32'd1);
    chk({name, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    chk({name, "_rsp_data"}, rsp_data, 32'd0);
    chk({name, "_rsp_err"}, {31'b0, rsp_err}, 32'd0);
    chk({name, "_strobes"}, {30'b0, read_req, write_req}, 32'd0);
    chk({name, "_write_data"}, write_data, 32'd0);
    chk({name, "_busy"}, {31'b0, busy}, 32'd0);
    chk({name, "_err_count"}, {24'b0, err_count}, 32'd0);
  endtask

  task automatic run_cmd(input vec_t v);
    logic acc;
    mode = v.mode;
    push_cmd(v.op, v.data, v.exp_data, v.exp_err, acc);
    chk("tbl_accept", {31'b0, acc}, 32'd1);
    tick();
    chk("tbl_strobe_e1", {30'b0, read_req, write_req}, {30'b0, v.op[0], v.op[1]});
    if (v.op[1]) chk("tbl_write_data", write_data, v.data);
    tick();
    chk("tbl_strobe_e2", {30'b0, read_req, write_req}, 32'd0);
    drain(40, "tbl");
    chk("tbl_busy", {31'b0, busy}, 32'd0);
    chk("tbl_err_count", {24'b0, err_count}, ecnt);
    mode = 0;
  endtask

  initial begin
    logic        acc;
    int          nacc;
    logic [1:0]  f_op  [6];
    logic [31:0] f_dat [6];
    logic [31:0] f_exp [6];
    logic        f_err [6];

    tbl[0] = '{2'b01, 32'h0000_0000, 0, 32'hA5A5_A5A5, 1'b0};
    tbl[1] = '{2'b11, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1'b0};
    tbl[2] = '{2'b10, 32'h1234_5678, 0, 32'h0000_0000, 1'b0};
    tbl[3] = '{2'b00, 32'hCAFE_F00D, 0, 32'h0000_0000, 1'b1};
    tbl[4] = '{2'b01, 32'h0000_0000, 1, 32'h0000_0000, 1'b1};
    tbl[5] = '{2'b10, 32'h0BAD_F00D, 2, 32'h0000_0000, 1'b1};
    tbl[6] = '{2'b01, 32'h0000_0000, 0, 32'h1234_5678, 1'b0};
    tbl[7] = '{2'b11, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 1'b0};

    f_op[0] = 2'b10; f_dat[0] = 32'h1111_1111; f_exp[0] = 32'h0;         f_err[0] = 1'b0;
    f_op[1] = 2'b01; f_dat[1] = 32'h0;         f_exp[1] = 32'h1111_1111; f_err[1] = 1'b0;
    f_op[2] = 2'b11; f_dat[2] = 32'h2222_2222; f_exp[2] = 32'h2222_2222; f_err[2] = 1'b0;
    f_op[3] = 2'b01; f_dat[3] = 32'h0;         f_exp[3] = 32'h2222_2222; f_err[3] = 1'b0;
    f_op[4] = 2'b00; f_dat[4] = 32'h0;         f_exp[4] = 32'h0;         f_err[4] = 1'b1;
    f_op[5] = 2'b10; f_dat[5] = 32'h3333_3333; f_exp[5] = 32'h0;         f_err[5] = 1'b0;

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 32'h0;
    rsp_ready = 1'b0;
    tick();
    tick();
    check_reset("reset");
    rst_n = 1'b1;
    tick();

    // WRITE with response held: exact strobe timing and 3-edge latency
    push_cmd(2'b10, 32'hA5A5_A5A5, 32'h0, 1'b0, acc);
    chk("w_e0_strobe", {31'b0, write_req}, 32'd0);
    chk("w_e0_busy", {31'b0, busy}, 32'd1);
    tick();
    chk("w_e1_write_req", {31'b0, write_req}, 32'd1);
    chk("w_e1_read_req", {31'b0, read_req}, 32'd0);
    chk("w_e1_write_data", write_data, 32'hA5A5_A5A5);
    tick();
    chk("w_e2_write_req", {31'b0, write_req}, 32'd0);
    chk("w_e2_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    tick();
    chk("w_e3_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    rsp_ready = 1'b1;
    drain(10, "w");

    for (int i = 0; i < 8; i++) run_cmd(tbl[i]);

    // Timeout: error response exactly TIMEOUT edges after the strobe drops
    rsp_ready = 1'b0;
    mode = 1;
    push_cmd(2'b01, 32'h0, 32'h0, 1'b1, acc);
    tick();
    tick();
    chk("to_strobe_dropped", {31'b0, read_req}, 32'd0);
    for (int i = 0; i < 15; i++) tick();
    chk("to_not_yet", {31'b0, rsp_valid}, 32'd0);
    tick();
    chk("to_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("to_rsp_err", {31'b0, rsp_err}, 32'd1);
    chk("to_err_count_before", {24'b0, err_count}, ecnt - 1);
    rsp_ready = 1'b1;
    drain(10, "to");
    chk("to_err_count_after", {24'b0, err_count}, ecnt);
    mode = 0;

    // FIFO full under backpressure: sixth push refused, the rest complete in order
    rsp_ready = 1'b0;
    nacc = 0;
    for (int i = 0; i < 6; i++) begin
      push_cmd(f_op[i], f_dat[i], f_exp[i], f_err[i], acc);
      if (acc) nacc++;
    end
    chk("full_accepted", nacc, 5);
    chk("full_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    rsp_ready = 1'b1;
    tick();
    chk("full_still_full", {31'b0, cmd_ready}, 32'd0);
    tick();
    chk("full_pop_frees", {31'b0, cmd_ready}, 32'd1);
    drain(60, "full");
    chk("full_busy", {31'b0, busy}, 32'd0);
    chk("full_err_count", {24'b0, err_count}, ecnt);

    // Reset during WAIT with a command still queued
    rsp_ready = 1'b0;
    push_cmd(2'b10, 32'h7777_7777, 32'h0, 1'b0, acc);
    push_cmd(2'b01, 32'h0, 32'h7777_7777, 1'b0, acc);
    chk("mid_write_req", {31'b0, write_req}, 32'd1);
    chk("mid_write_data", write_data, 32'h7777_7777);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("mid_reset");
    sb.delete();
    ecnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    rsp_ready = 1'b1;
    run_cmd('{2'b11, 32'h5A5A_5A5A, 0, 32'h5A5A_5A5A, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
